ip_codma_crc_engine: RTL and testbench
======================================

# ip_codma_crc_engine

CRC-32 checker for the codma core. It sits downstream of the data-read path and consumes the words fetched while the core DMA machine is in DMA_DATA_READ. It computes an IEEE 802.3 reflected CRC-32 over a programmed number of 32-bit words and reports the result to the core machine, which uses it in DMA_CRC before moving to DMA_WRITING. Words are processed byte-serially, LSB byte first, one byte per cycle.

## Interface
Parameters:
- LEN_W, 16: width of the word-count input.
- CRC_INIT, 32'hFFFF_FFFF: CRC register seed loaded on start.

Ports:
- Clock and reset: one clock, `clk_i`; reset `reset_i` is asynchronous and active-high.
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- start_i  in  1  begin a CRC run (sampled in IDLE only)
- abort_i  in  1  cancel current run
- len_i  in  LEN_W  number of 32-bit words, sampled with start_i
- data_i  in  32  data word, byte 0 = data_i[7:0]
- data_valid_i  in  1  data word valid
- data_ready_o  out  1  engine can accept a word
- busy_o  out  1  run in progress (state != IDLE)
- done_o  out  1  single-cycle pulse, CRC result valid
- crc_o  out  32  CRC result, held until next start_i accepted

## Operation
- States: CRC_IDLE, CRC_WAIT, CRC_BYTE, CRC_DONE.
- IDLE:
  - start_i=1 loads crc_r=CRC_INIT and words_left_r=len_i.
  - If len_i==0, go to DONE; otherwise go to WAIT.
  - start_i while not IDLE is ignored.
- WAIT:
  - data_ready_o=1.
  - On data_valid_i&data_ready_o: capture data_i into word_r, set byte_idx_r=0, decrement words_left_r, go to BYTE.
- BYTE:
  - data_ready_o=0.
  - Each cycle, crc_r is stepped over word_r byte byte_idx_r: XOR the byte into crc_r[7:0], then 8 bit-steps, each shift right, XOR 32'hEDB88320 when the shifted-out bit was 1.
  - After byte_idx_r==3: if words_left_r==0 go to DONE, else go to WAIT.
- DONE:
  - Load crc_o from crc_r (final transform per Configuration), pulse done_o for one cycle, go to IDLE.
- abort_i:
  - Takes priority in any state other than IDLE. Next state is IDLE, and done_o is not pulsed.
  - crc_o is unchanged, and any word offered in the same cycle is not accepted.
- Arithmetic:
  - words_left_r is LEN_W bits and never decrements below 0, since the decrement happens only in WAIT with words_left_r≥1.
  - byte_idx_r is 2 bits and wraps 3→0 only on word capture.

## Timing
- Reset values: data_ready_o=0, busy_o=0, done_o=0, crc_o=32'h0. Internal: state IDLE, crc_r=CRC_INIT, counters 0.
- Reset asserted mid-run returns to IDLE immediately, with no done_o.
- Latency, all registered outputs:
  - start_i in cycle 0 gives WAIT (data_ready_o=1) in cycle 1.
  - Each accepted word costs 5 cycles: 1 WAIT plus 4 BYTE.
  - With no stalls, done_o occurs in cycle 5N+1 after start.
  - With len_i==0, done_o occurs in cycle 1.
- data_ready_o is a function of state only. The upstream source may hold data_valid_i high and change data only after a handshake.
- data_valid_i outside WAIT has no effect.
- start_i and abort_i in the same IDLE cycle: start wins, because abort is ignored in IDLE.

## Configuration
- CODMA_CRC_FINAL_XOR_EN:
  - Defined: crc_o = crc_r ^ 32'hFFFF_FFFF at DONE, giving standard CRC-32.
  - Undefined: crc_o = crc_r (raw register), used when the core chains or compares against an uninverted value.

## Structure
- Add `crc_state_t` (2-bit enum CRC_IDLE=00, CRC_WAIT=01, CRC_BYTE=10, CRC_DONE=11) and the `crc_state_r`/`crc_state_next_s` declarations to ip_codma_machine_states_pkg.
- Add constant CODMA_CRC_POLY=32'hEDB88320 to the same package.
- Sub-module ip_codma_crc_byte: purely combinational single-byte step, crc_in(32) + byte(8) → crc_out(32). It is instantiated once, fed by a byte mux on byte_idx_r.

## Test plan
- Single word "1234": len_i=1, data_i=32'h34333231, FINAL_XOR_EN defined → crc_o=32'h9BE3E0A3, done_o in cycle 6 after start.
- Same word with the macro undefined → crc_o=32'h641C1F5C.
- One zero word: len_i=1, data_i=0 → crc_o=32'h2144DF1C.
- Zero length: len_i=0 → done_o in cycle 1, crc_o=32'h00000000 (macro defined).
- Stall/abort:
  - len_i=3 with data_valid_i low for 7 cycles between words → same CRC as the unstalled run.
  - abort_i during the 2nd BYTE cycle → IDLE next cycle, no done_o, crc_o unchanged.
- Reset mid-run: assert reset_i asynchronously during BYTE → all outputs return to reset values within the same cycle. A following start with len_i=1 gives the correct CRC.

Source files
------------

// File: rtl/ip_codma_machine_states_pkg.sv
// Shared state encodings and constants for the codma core machines.
package ip_codma_machine_states_pkg;

    typedef enum logic [1:0] {
        CRC_IDLE = 2'b00,
        CRC_WAIT = 2'b01,
        CRC_BYTE = 2'b10,
        CRC_DONE = 2'b11
    } crc_state_t;

    // Reflected IEEE 802.3 polynomial.
    localparam logic [31:0] CODMA_CRC_POLY = 32'hEDB8_8320;

endpackage

// File: rtl/ip_codma_crc_engine_if.sv
// Control and data handshake between the codma core machine and the CRC engine.
interface ip_codma_crc_engine_if #(
    parameter int LEN_W = 16
);
    logic             start_i;
    logic             abort_i;
    logic [LEN_W-1:0] len_i;
    logic [31:0]      data_i;
    logic             data_valid_i;
    logic             data_ready_o;
    logic             busy_o;
    logic             done_o;
    logic [31:0]      crc_o;

    modport master (
        output start_i, abort_i, len_i, data_i, data_valid_i,
        input  data_ready_o, busy_o, done_o, crc_o
    );

    modport slave (
        input  start_i, abort_i, len_i, data_i, data_valid_i,
        output data_ready_o, busy_o, done_o, crc_o
    );
endinterface

// File: rtl/ip_codma_crc_engine_crc_byte.sv
// Combinational reflected CRC-32 step over one byte.
module ip_codma_crc_byte
    import ip_codma_machine_states_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_byte,
    output logic [31:0] crc_out
);
    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data_byte};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CODMA_CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end
endmodule

// File: rtl/ip_codma_crc_engine.sv
// Byte-serial CRC-32 over a programmed number of 32-bit words.
// CODMA_CRC_FINAL_XOR_EN: when defined, crc_o is inverted (standard CRC-32).
module ip_codma_crc_engine
    import ip_codma_machine_states_pkg::*;
#(
    parameter int          LEN_W    = 16,
    parameter logic [31:0] CRC_INIT = 32'hFFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    ip_codma_crc_engine_if.slave bus
);
`ifdef CODMA_CRC_FINAL_XOR_EN
    localparam logic [31:0] FINAL_XOR = '1;
`else
    localparam logic [31:0] FINAL_XOR = '0;
`endif

    crc_state_t       crc_state_r;
    logic [31:0]      crc_r;
    logic [31:0]      word_r;
    logic [LEN_W-1:0] words_left_r;
    logic [1:0]       byte_idx_r;
    logic [7:0]       cur_byte;
    logic [31:0]      crc_step;

    always_comb begin
        cur_byte = word_r[{byte_idx_r, 3'b000} +: 8];
    end

    ip_codma_crc_byte u_crc_byte (
        .crc_in    (crc_r),
        .data_byte (cur_byte),
        .crc_out   (crc_step)
    );

    // done_o and crc_o are loaded on entry to DONE so the pulse lands in cycle 5N+1.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            crc_state_r      <= CRC_IDLE;
            crc_r            <= CRC_INIT;
            word_r           <= '0;
            words_left_r     <= '0;
            byte_idx_r       <= '0;
            bus.data_ready_o <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.crc_o        <= '0;
        end else begin
            bus.done_o <= 1'b0;
            if (crc_state_r != CRC_IDLE && bus.abort_i) begin
                crc_state_r      <= CRC_IDLE;
                bus.data_ready_o <= 1'b0;
                bus.busy_o       <= 1'b0;
            end else begin
                case (crc_state_r)
                    CRC_IDLE: begin
                        if (bus.start_i) begin
                            crc_r        <= CRC_INIT;
                            words_left_r <= bus.len_i;
                            bus.busy_o   <= 1'b1;
                            if (bus.len_i == '0) begin
                                crc_state_r <= CRC_DONE;
                                bus.done_o  <= 1'b1;
                                bus.crc_o   <= CRC_INIT ^ FINAL_XOR;
                            end else begin
                                crc_state_r      <= CRC_WAIT;
                                bus.data_ready_o <= 1'b1;
                            end
                        end
                    end
                    CRC_WAIT: begin
                        if (bus.data_valid_i) begin
                            word_r           <= bus.data_i;
                            byte_idx_r       <= '0;
                            words_left_r     <= words_left_r - LEN_W'(1);
                            crc_state_r      <= CRC_BYTE;
                            bus.data_ready_o <= 1'b0;
                        end
                    end
                    CRC_BYTE: begin
                        crc_r <= crc_step;
                        if (byte_idx_r == 2'd3) begin
                            if (words_left_r == '0) begin
                                crc_state_r <= CRC_DONE;
                                bus.done_o  <= 1'b1;
                                bus.crc_o   <= crc_step ^ FINAL_XOR;
                            end else begin
                                crc_state_r      <= CRC_WAIT;
                                bus.data_ready_o <= 1'b1;
                            end
                        end else begin
                            byte_idx_r <= byte_idx_r + 2'd1;
                        end
                    end
                    CRC_DONE: begin
                        crc_state_r <= CRC_IDLE;
                        bus.busy_o  <= 1'b0;
                    end
                    default: crc_state_r <= CRC_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ip_codma_crc_engine.sv
// Directed bench for ip_codma_crc_engine: vector table plus abort/stall/reset sequences.
module tb_ip_codma_crc_engine;
`ifdef CODMA_CRC_FINAL_XOR_EN
    localparam logic [31:0] FX = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] FX = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ip_codma_crc_engine_if #(.LEN_W(16)) bus ();

    ip_codma_crc_engine #(.LEN_W(16), .CRC_INIT(32'hFFFF_FFFF)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        int          n;
        logic [31:0] data;
        logic [31:0] raw;
        int          done_cyc;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input int n, input logic [31:0] w0, w1, w2);
        logic [31:0] c;
        logic [31:0] w[3];
        logic        fb;
        c = 32'hFFFF_FFFF;
        w = '{w0, w1, w2};
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 32; k++) begin
                fb = c[0] ^ w[i][k];
                c  = c >> 1;
                if (fb) c = c ^ 32'hEDB8_8320;
            end
        end
        return c;
    endfunction

    // Cycle 0 is the cycle start_i is high; outputs are sampled on the falling edge.
    task automatic run_job(input int n, input logic [31:0] w0, w1, w2, input int gap, input bit poke,
                           output int done_cyc, output int pulses, output logic [31:0] crc,
                           output logic busy_end);
        logic [31:0] w[3];
        int idx;
        int hold;
        w = '{w0, w1, w2};
        done_cyc = -1; pulses = 0; idx = 0; hold = 0; crc = '0; busy_end = 1'b1;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.len_i   = 16'(n);
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            bus.start_i      = 1'b0;
            bus.data_valid_i = 1'b0;
            if (bus.done_o) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    crc      = bus.crc_o;
                end
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 3) begin
                busy_end = bus.busy_o;
                break;
            end
            if (bus.data_ready_o && idx < n) begin
                if (idx > 0 && hold < gap) begin
                    hold++;
                    if (poke && hold == 1) begin
                        bus.start_i = 1'b1;
                        bus.len_i   = 16'd0;
                    end
                end else begin
                    bus.data_valid_i = 1'b1;
                    bus.data_i       = w[idx];
                    idx++;
                    hold = 0;
                end
            end
        end
        bus.start_i      = 1'b0;
        bus.data_valid_i = 1'b0;
    endtask

    initial begin
        int          dc;
        int          pl;
        logic [31:0] crc;
        logic        be;
        logic [31:0] multi_exp;
        int          seen;

        vecs[0] = '{"w1234",  1, 32'h3433_3231, 32'h641C_1F5C, 6};
        vecs[1] = '{"wzero",  1, 32'h0000_0000, 32'hDEBB_20E3, 6};
        vecs[2] = '{"wones",  1, 32'hFFFF_FFFF, 32'h0000_0000, 6};
        vecs[3] = '{"len0",   0, 32'h0000_0000, 32'hFFFF_FFFF, 1};

        bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.len_i = '0;
        bus.data_i = '0; bus.data_valid_i = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_crc", bus.crc_o, 32'h0);
        check("reset_flags", {29'h0, bus.data_ready_o, bus.busy_o, bus.done_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_job(vecs[i].n, vecs[i].data, 32'h0, 32'h0, 0, 1'b0, dc, pl, crc, be);
            check({vecs[i].name, "_crc"}, crc, vecs[i].raw ^ FX);
            check({vecs[i].name, "_cycle"}, 32'(dc), 32'(vecs[i].done_cyc));
            check({vecs[i].name, "_pulses"}, 32'(pl), 32'd1);
            check({vecs[i].name, "_busy_end"}, {31'h0, be}, 32'h0);
        end

        multi_exp = crc_model(3, 32'h6463_6261, 32'h6867_6665, 32'h6C6B_6A69) ^ FX;
        run_job(3, 32'h6463_6261, 32'h6867_6665, 32'h6C6B_6A69, 0, 1'b0, dc, pl, crc, be);
        check("len3_crc", crc, multi_exp);
        check("len3_cycle", 32'(dc), 32'd16);

        run_job(3, 32'h6463_6261, 32'h6867_6665, 32'h6C6B_6A69, 7, 1'b1, dc, pl, crc, be);
        check("len3_stall_crc", crc, multi_exp);
        check("len3_stall_cycle", 32'(dc), 32'd30);
        check("len3_stall_pulses", 32'(pl), 32'd1);

        // Abort during the second BYTE cycle.
        @(negedge clk); bus.start_i = 1'b1; bus.len_i = 16'd2;
        @(negedge clk); bus.start_i = 1'b0; bus.data_valid_i = 1'b1; bus.data_i = 32'h3433_3231;
        @(negedge clk); bus.data_valid_i = 1'b0;
        @(negedge clk); bus.abort_i = 1'b1;
        @(negedge clk); bus.abort_i = 1'b0;
        check("abort_byte_flags", {29'h0, bus.data_ready_o, bus.busy_o, bus.done_o}, 32'h0);
        check("abort_byte_crc", bus.crc_o, multi_exp);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.done_o) seen++;
        end
        check("abort_byte_no_done", 32'(seen), 32'd0);

        // Abort in WAIT with a word offered in the same cycle.
        @(negedge clk); bus.start_i = 1'b1; bus.len_i = 16'd1;
        @(negedge clk); bus.start_i = 1'b0; bus.data_valid_i = 1'b1; bus.data_i = 32'h0; bus.abort_i = 1'b1;
        @(negedge clk); bus.data_valid_i = 1'b0; bus.abort_i = 1'b0;
        check("abort_wait_flags", {29'h0, bus.data_ready_o, bus.busy_o, bus.done_o}, 32'h0);
        check("abort_wait_crc", bus.crc_o, multi_exp);
        run_job(1, 32'h3433_3231, 32'h0, 32'h0, 0, 1'b0, dc, pl, crc, be);
        check("post_abort_crc", crc, 32'h641C_1F5C ^ FX);
        check("post_abort_cycle", 32'(dc), 32'd6);

        // Asynchronous reset in the middle of a BYTE cycle.
        @(negedge clk); bus.start_i = 1'b1; bus.len_i = 16'd1;
        @(negedge clk); bus.start_i = 1'b0; bus.data_valid_i = 1'b1; bus.data_i = 32'h0;
        @(negedge clk); bus.data_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_crc", bus.crc_o, 32'h0);
        check("midrst_flags", {29'h0, bus.data_ready_o, bus.busy_o, bus.done_o}, 32'h0);
        @(negedge clk); rst = 1'b0;
        run_job(1, 32'h3433_3231, 32'h0, 32'h0, 0, 1'b0, dc, pl, crc, be);
        check("post_rst_crc", crc, 32'h641C_1F5C ^ FX);
        check("post_rst_cycle", 32'(dc), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
